multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multi-cycle RV32I core variant. It sequences a shared datapath (one ALU, one unified instruction/data memory port, one register file) through fetch, decode, execute, memory and writeback. It drives `aluOP` into the existing ALU control decoder and handshakes with the memory-mapped bus, so UART and other slow peripherals can stall any access.

## Interface
Parameters
- `RESET_STATE_FETCH`, 1: when 1, the FSM leaves reset in FETCH. When 0, it leaves reset in a single IDLE cycle before FETCH.

Ports
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low: one clock, asynchronous active-low reset.
- `opcode`  in  7  `instr[6:0]` from the instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  bus completion for the current access.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write strobe, valid with `mem_req`.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load the IR and latch oldPC.
- `pc_write`  out  1  update the PC (unconditional, or taken branch).
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  2  00 = PC, 01 = oldPC, 10 = reg A.
- `alu_src_b`  out  2  00 = reg B, 01 = imm, 10 = constant 4.
- `aluOP`  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- `funct7_mask`  out  1  datapath forces `funct7` to 0 when high.
- `result_src`  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- `illegal`  out  1  sticky trap flag.
- `instr_retired`  out  1  one-cycle pulse per completed instruction.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, TRAP.
- FETCH:
  - Drives `mem_req=1`, `adr_src=0`, `alu_src_a=00`, `alu_src_b=10`, `aluOP=00`.
  - On `mem_ready`: `ir_write=1`, `pc_write=1`, then go to DECODE. Otherwise hold state with all outputs stable.
- DECODE computes the branch target (`alu_src_a=01`, `alu_src_b=01`, `aluOP=00`). Next state by opcode:
  - `0000011` or `0100011` → MEM_ADR.
  - `0110011` → EXEC_R.
  - `1100011` → BRANCH.
  - `0010011` → EXEC_I (with `MC_ITYPE_EN` only).
  - Anything else → TRAP.
- MEM_ADR: `alu_src_a=10`, `alu_src_b=01`, `aluOP=00`. Goes to MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: `mem_req=1`, `adr_src=1`. Waits for `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write=1`, `result_src=01`, `instr_retired=1`, then FETCH.
- MEM_WRITE: `mem_req=1`, `mem_we=1`, `adr_src=1`. On `mem_ready`: `instr_retired=1`, then FETCH.
- EXEC_R: `alu_src_a=10`, `alu_src_b=00`, `aluOP=10`, then ALU_WB.
- EXEC_I: `alu_src_a=10`, `alu_src_b=01`, `aluOP=10`, `funct7_mask=1`, then ALU_WB.
- ALU_WB: `reg_write=1`, `result_src=00`, `instr_retired=1`, then FETCH.
- BRANCH:
  - Drives `alu_src_a=10`, `alu_src_b=00`, `aluOP=01`, `result_src=00`.
  - `pc_write=zero`, i.e. the branch target latched in DECODE is written only when taken.
  - `instr_retired=1`, then FETCH.
- TRAP: `illegal=1`, all other outputs 0. Absorbing state, exited only by reset.
- Outputs are Moore-decoded from state, except `ir_write`, `pc_write` and `instr_retired`, which are gated by `mem_ready`/`zero` as stated above.
- Outputs not listed for a state are 0.

## Timing
- Reset (async assert, synchronous-to-clk deassert edge):
  - State goes to FETCH (or IDLE).
  - Every output is 0, including `illegal`.
  - `aluOP` resets to 00.
- Reset mid-access drops `mem_req` immediately. The bus must tolerate an abandoned request.
- `mem_req`/`mem_we`/`adr_src` are held constant from the first request cycle until the cycle `mem_ready` is high. That cycle completes the access, and the next state is entered on the following edge.
- `mem_ready` is ignored outside FETCH/MEM_READ/MEM_WRITE.
- Cycle counts with zero-wait memory (`mem_ready` already high):
  - lw 5.
  - sw 4.
  - R-type 4.
  - I-type 4.
  - beq 3.
- Each wait cycle adds one cycle.
- `instr_retired` rises exactly once per instruction, never in TRAP.

## Configuration
- `MC_ITYPE_EN` defined:
  - Opcode `0010011` is legal, and EXEC_I exists.
  - `funct7_mask` is driven.
  - Supported funct3 values are 000, 110 and 111 (addi/ori/andi). The core treats other funct3 values as add via the ALU decoder default.
- `MC_ITYPE_EN` undefined:
  - EXEC_I is not compiled, and `funct7_mask` is tied to 0.
  - Opcode `0010011` goes to TRAP.

## Structure
- Package `mc_pkg`:
  - State enum.
  - Opcode constants (LOAD, STORE, RTYPE, BRANCH, ITYPE).
  - aluOP encodings shared with the ALU control decoder.
  - `alu_src_a`/`alu_src_b`/`result_src` encodings.
- One sub-module, `mc_opcode_decode`: combinational opcode → instruction-class one-hot plus a legal bit, used by DECODE and MEM_ADR.

## Test plan
- Reset held low for 3 cycles, then released, with `mem_ready=1`: FETCH first with `mem_req=1`, and all outputs 0 while in reset.
- lw (`opcode=0000011`) with `mem_ready` low for 2 cycles in MEM_READ: 7 cycles total, `reg_write`+`result_src=01` in the final cycle, exactly one `instr_retired`.
- beq twice, with `zero=1` and then `zero=0`: `pc_write` high in BRANCH only for the first; both take 3 cycles.
- R-type sub: `aluOP=10` in EXEC_R, `reg_write=1` with `result_src=00` next cycle, 4 cycles total.
- Opcode `1111111`: TRAP after DECODE, `illegal=1` sticky for 20 cycles, no `mem_req`. Reset clears it.
- Opcode `0010011`:
  - With `MC_ITYPE_EN`: `funct7_mask=1`, `aluOP=10`, 4 cycles.
  - Without it: TRAP.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control FSM.
// The optional I-type path is enabled with the MC_ITYPE_EN macro.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic load;
    logic store;
    logic rtype;
    logic branch;
    logic itype;
  } iclass_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       funct7_mask;
    logic [1:0] result_src;
    logic       illegal;
    logic       instr_retired;
  } ctrl_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Opcode to one-hot instruction class plus legal bit.
// I-type is only recognised when MC_ITYPE_EN is defined.
module mc_opcode_decode
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic       legal
);

  always_comb begin
    cls        = '0;
    cls.load   = (opcode == OP_LOAD);
    cls.store  = (opcode == OP_STORE);
    cls.rtype  = (opcode == OP_RTYPE);
    cls.branch = (opcode == OP_BRANCH);
`ifdef MC_ITYPE_EN
    cls.itype  = (opcode == OP_ITYPE);
`endif
    legal      = |cls;
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core.
// Define MC_ITYPE_EN to add the EXEC_I state (addi/ori/andi).
module multicycle_control
  import mc_pkg::*;
#(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluOP,
  output logic       funct7_mask,
  output logic [1:0] result_src,
  output logic       illegal,
  output logic       instr_retired
);

  localparam state_t RST_STATE =
    RESET_STATE_FETCH ? S_FETCH : S_IDLE;

  state_t  state;
  iclass_t cls;
  logic    legal;
  ctrl_t   c;

  mc_opcode_decode u_dec (
    .opcode (opcode),
    .cls    (cls),
    .legal  (legal)
  );

`ifndef MC_ITYPE_EN
  logic unused_itype;
  assign unused_itype = cls.itype;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
    end else begin
      unique case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            !legal:             state <= S_TRAP;
            cls.load, cls.store: state <= S_MEM_ADR;
            cls.rtype:          state <= S_EXEC_R;
            cls.branch:         state <= S_BRANCH;
`ifdef MC_ITYPE_EN
            cls.itype:          state <= S_EXEC_I;
`endif
            default:            state <= S_TRAP;
          endcase
        end
        S_MEM_ADR:
          state <= cls.store ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ: if (mem_ready) state <= S_MEM_WB;
        S_MEM_WB:   state <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
        S_EXEC_R:   state <= S_ALU_WB;
`ifdef MC_ITYPE_EN
        S_EXEC_I:   state <= S_ALU_WB;
`endif
        S_ALU_WB:   state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_TRAP;
      endcase
    end
  end

  // Moore decode; reset also masks outputs so an in-flight
  // request is dropped the moment rst_n falls.
  always_comb begin
    c = '0;
    unique case (state)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_ADR: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write     = 1'b1;
        c.result_src    = RES_MEM;
        c.instr_retired = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_req       = 1'b1;
        c.mem_we        = 1'b1;
        c.adr_src       = 1'b1;
        c.instr_retired = mem_ready;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_FUNCT;
      end
`ifdef MC_ITYPE_EN
      S_EXEC_I: begin
        c.alu_src_a   = SRCA_REG;
        c.alu_src_b   = SRCB_IMM;
        c.alu_op      = ALU_FUNCT;
        c.funct7_mask = 1'b1;
      end
`endif
      S_ALU_WB: begin
        c.reg_write     = 1'b1;
        c.result_src    = RES_ALUOUT;
        c.instr_retired = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRCA_REG;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALU_SUB;
        c.result_src    = RES_ALUOUT;
        c.pc_write      = zero;
        c.instr_retired = 1'b1;
      end
      S_TRAP:  c.illegal = 1'b1;
      default: c = '0;
    endcase
    if (!rst_n) c = '0;
  end

  assign mem_req       = c.mem_req;
  assign mem_we        = c.mem_we;
  assign adr_src       = c.adr_src;
  assign ir_write      = c.ir_write;
  assign pc_write      = c.pc_write;
  assign reg_write     = c.reg_write;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign aluOP         = c.alu_op;
  assign funct7_mask   = c.funct7_mask;
  assign result_src    = c.result_src;
  assign illegal       = c.illegal;
  assign instr_retired = c.instr_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle output
// traces from a scoreboard queue of expected control vectors.
module tb_multicycle_control;

  localparam int T_FETCH = 1, T_DECODE = 2, T_MADR = 3;
  localparam int T_MRD = 4, T_MWB = 5, T_MWR = 6;
  localparam int T_EXR = 7, T_EXI = 8, T_AWB = 9;
  localparam int T_BR = 10, T_TRAP = 11;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write;
  logic       reg_write, funct7_mask, illegal, instr_retired;
  logic [1:0] alu_src_a, alu_src_b, aluOP, result_src;

  int checks = 0;
  int failures = 0;

  logic [17:0] exp_q[$];
  logic        rdy_q[$];
  logic [6:0]  op_q[$];
  logic        z_q[$];

  logic [17:0] obs;
  assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write,
                reg_write, alu_src_a, alu_src_b, aluOP,
                funct7_mask, result_src, illegal, instr_retired};

  multicycle_control #(.RESET_STATE_FETCH(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .aluOP         (aluOP),
    .funct7_mask   (funct7_mask),
    .result_src    (result_src),
    .illegal       (illegal),
    .instr_retired (instr_retired)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] exp_vec(input int s,
                                          input logic r,
                                          input logic z);
    logic req, we, adr, irw, pcw, rw, msk, ill, ret;
    logic [1:0] a, b, op, rs;
    {req, we, adr, irw, pcw, rw, msk, ill, ret} = '0;
    {a, b, op, rs} = '0;
    case (s)
      T_FETCH:  begin req = 1; b = 2'b10; irw = r; pcw = r; end
      T_DECODE: begin a = 2'b01; b = 2'b01; end
      T_MADR:   begin a = 2'b10; b = 2'b01; end
      T_MRD:    begin req = 1; adr = 1; end
      T_MWB:    begin rw = 1; rs = 2'b01; ret = 1; end
      T_MWR:    begin req = 1; we = 1; adr = 1; ret = r; end
      T_EXR:    begin a = 2'b10; op = 2'b10; end
      T_EXI:    begin a = 2'b10; b = 2'b01; op = 2'b10; msk = 1; end
      T_AWB:    begin rw = 1; ret = 1; end
      T_BR:     begin a = 2'b10; op = 2'b01; pcw = z; ret = 1; end
      T_TRAP:   ill = 1;
      default:  ;
    endcase
    return {req, we, adr, irw, pcw, rw, a, b, op, msk, rs, ill, ret};
  endfunction

  task automatic push(input int s, input logic r,
                      input logic [6:0] op, input logic z);
    exp_q.push_back(exp_vec(s, r, z));
    rdy_q.push_back(r);
    op_q.push_back(op);
    z_q.push_back(z);
  endtask

  task automatic plan(input logic [6:0] op, input int wf,
                      input int wm, input logic z);
    for (int i = 0; i < wf; i++) push(T_FETCH, 1'b0, op, z);
    push(T_FETCH, 1'b1, op, z);
    push(T_DECODE, 1'($urandom_range(0, 1)), op, z);
    case (op)
      LW: begin
        push(T_MADR, 1'($urandom_range(0, 1)), op, z);
        for (int i = 0; i < wm; i++) push(T_MRD, 1'b0, op, z);
        push(T_MRD, 1'b1, op, z);
        push(T_MWB, 1'($urandom_range(0, 1)), op, z);
      end
      SW: begin
        push(T_MADR, 1'($urandom_range(0, 1)), op, z);
        for (int i = 0; i < wm; i++) push(T_MWR, 1'b0, op, z);
        push(T_MWR, 1'b1, op, z);
      end
      RT: begin
        push(T_EXR, 1'($urandom_range(0, 1)), op, z);
        push(T_AWB, 1'($urandom_range(0, 1)), op, z);
      end
      BEQ: push(T_BR, 1'($urandom_range(0, 1)), op, z);
`ifdef MC_ITYPE_EN
      IT: begin
        push(T_EXI, 1'($urandom_range(0, 1)), op, z);
        push(T_AWB, 1'($urandom_range(0, 1)), op, z);
      end
`endif
      default: push(T_TRAP, 1'($urandom_range(0, 1)), op, z);
    endcase
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (obs !== 18'd0) begin
        failures++;
        $display("FAIL reset_outputs got=%b exp=%b", obs, 18'd0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== exp_vec(T_FETCH, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL reset_first_fetch got=%b exp=%b",
               obs, exp_vec(T_FETCH, 1'b0, 1'b0));
    end
  endtask

  task automatic test_lw;
    logic [17:0] e;
    int ret_n = 0;
    int cyc = 0;
    plan(LW, 0, 2, 1'b0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      opcode = op_q.pop_front();
      zero = z_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL lw_trace cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      ret_n += int'(instr_retired);
      cyc++;
    end
    checks++;
    if (ret_n !== 1) begin
      failures++;
      $display("FAIL lw_retired got=%0d exp=1", ret_n);
    end
  endtask

  task automatic test_beq;
    logic [17:0] e;
    int ret_n = 0;
    int cyc = 0;
    plan(BEQ, 0, 0, 1'b1);
    plan(BEQ, 0, 0, 1'b0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      opcode = op_q.pop_front();
      zero = z_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL beq_trace cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      ret_n += int'(instr_retired);
      cyc++;
    end
    checks++;
    if (ret_n !== 2) begin
      failures++;
      $display("FAIL beq_retired got=%0d exp=2", ret_n);
    end
  endtask

  task automatic test_rtype;
    logic [17:0] e;
    int ret_n = 0;
    int cyc = 0;
    plan(RT, 0, 0, 1'b0);
    plan(RT, 1, 0, 1'b1);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      opcode = op_q.pop_front();
      zero = z_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rtype_trace cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      ret_n += int'(instr_retired);
      cyc++;
    end
    checks++;
    if (ret_n !== 2) begin
      failures++;
      $display("FAIL rtype_retired got=%0d exp=2", ret_n);
    end
  endtask

  task automatic test_sw;
    logic [17:0] e;
    int ret_n = 0;
    int cyc = 0;
    plan(SW, 0, 0, 1'b0);
    plan(SW, 0, 3, 1'b0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      opcode = op_q.pop_front();
      zero = z_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sw_trace cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      ret_n += int'(instr_retired);
      cyc++;
    end
    checks++;
    if (ret_n !== 2) begin
      failures++;
      $display("FAIL sw_retired got=%0d exp=2", ret_n);
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] e;
    int ret_n = 0;
    int cyc = 0;
    plan(LW, 0, 0, 1'b0);
    plan(SW, 0, 0, 1'b1);
    plan(RT, 0, 0, 1'b1);
    plan(BEQ, 0, 0, 1'b1);
    plan(LW, 2, 1, 1'b0);
    plan(BEQ, 0, 0, 1'b0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      opcode = op_q.pop_front();
      zero = z_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL b2b_trace cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      ret_n += int'(instr_retired);
      cyc++;
    end
    checks++;
    if (ret_n !== 6) begin
      failures++;
      $display("FAIL b2b_retired got=%0d exp=6", ret_n);
    end
  endtask

  task automatic test_itype;
    logic [17:0] e;
    int ret_n = 0;
    int cyc = 0;
    plan(IT, 0, 0, 1'b0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      opcode = op_q.pop_front();
      zero = z_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL itype_trace cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      ret_n += int'(instr_retired);
      cyc++;
    end
`ifdef MC_ITYPE_EN
    checks++;
    if (ret_n !== 1) begin
      failures++;
      $display("FAIL itype_retired got=%0d exp=1", ret_n);
    end
`else
    checks++;
    if (ret_n !== 0) begin
      failures++;
      $display("FAIL itype_trap_retired got=%0d exp=0", ret_n);
    end
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== 18'd0) begin
      failures++;
      $display("FAIL itype_trap_reset got=%b exp=%b", obs, 18'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
`endif
  endtask

  task automatic test_trap;
    logic [17:0] e;
    int ret_n = 0;
    int cyc = 0;
    plan(BAD, 0, 0, 1'b0);
    repeat (20) push(T_TRAP, 1'($urandom_range(0, 1)), BAD, 1'b0);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      opcode = op_q.pop_front();
      zero = z_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL trap_trace cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      ret_n += int'(instr_retired);
      cyc++;
    end
    checks++;
    if (ret_n !== 0) begin
      failures++;
      $display("FAIL trap_retired got=%0d exp=0", ret_n);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL trap_reset_clear got=%b exp=0", illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== exp_vec(T_FETCH, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL trap_refetch got=%b exp=%b",
               obs, exp_vec(T_FETCH, 1'b0, 1'b0));
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL midaccess_reset_req got=%b exp=0", mem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_rtype();
    test_sw();
    test_back_to_back();
    test_itype();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
